// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: ID/EX stage register with stall, flush, saturating bubble counter.
// Define FWD_WB_BYPASS_EN to forward a same-cycle WB write into the captured operands.
module id_ex_pipeline_register #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_pc4,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       id_result_src,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_wd,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_pc4,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [1:0]       ex_result_src,
    output logic [3:0]       ex_alu_ctrl,
    output logic [CNT_W-1:0] bubble_count
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
    } ex_t;

    ex_t             pipe_d, pipe_q, cap;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [XLEN-1:0] op1, op2;
    logic            bubble, load;

    assign bubble = flush | (~stall & ~id_valid);
    assign load   = ~flush & ~stall & id_valid;

`ifdef FWD_WB_BYPASS_EN
    // Register file writes on the same edge it is read, so the WB value must be forwarded here.
    assign op1 = (wb_we && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wd : id_rd1;
    assign op2 = (wb_we && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wd : id_rd2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_rd, wb_wd};
    assign op1 = id_rd1;
    assign op2 = id_rd2;
`endif

    always_comb begin
        cap = '{valid: 1'b1, pc: id_pc, pc4: id_pc4, rd1: op1, rd2: op2, imm: id_imm,
                rs1: id_rs1, rs2: id_rs2, rd: id_rd, reg_write: id_reg_write,
                mem_read: id_mem_read, mem_write: id_mem_write, alu_src: id_alu_src,
                branch: id_branch, jump: id_jump, result_src: id_result_src,
                alu_ctrl: id_alu_ctrl};
        pipe_d = bubble ? '0 : load ? cap : pipe_q;
        cnt_d  = (bubble && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid      = pipe_q.valid;
    assign ex_pc         = pipe_q.pc;
    assign ex_pc4        = pipe_q.pc4;
    assign ex_rd1        = pipe_q.rd1;
    assign ex_rd2        = pipe_q.rd2;
    assign ex_imm        = pipe_q.imm;
    assign ex_rs1        = pipe_q.rs1;
    assign ex_rs2        = pipe_q.rs2;
    assign ex_rd         = pipe_q.rd;
    assign ex_reg_write  = pipe_q.reg_write;
    assign ex_mem_read   = pipe_q.mem_read;
    assign ex_mem_write  = pipe_q.mem_write;
    assign ex_alu_src    = pipe_q.alu_src;
    assign ex_branch     = pipe_q.branch;
    assign ex_jump       = pipe_q.jump;
    assign ex_result_src = pipe_q.result_src;
    assign ex_alu_ctrl   = pipe_q.alu_ctrl;
    assign bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb_id_ex_pipeline_register: directed checks of load, stall, flush, reset, bubble count and WB bypass.
module tb_id_ex_pipeline_register;
    logic        clk = 0, rst = 0, stall = 0, flush = 0, id_valid = 0;
    logic [31:0] id_pc = 0, id_pc4 = 0, id_rd1 = 0, id_rd2 = 0, id_imm = 0, wb_wd = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0, wb_rd = 0;
    logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_alu_src = 0;
    logic        id_branch = 0, id_jump = 0, wb_we = 0;
    logic [1:0]  id_result_src = 0;
    logic [3:0]  id_alu_ctrl = 0;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump;
    logic [31:0] ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_result_src;
    logic [3:0]  ex_alu_ctrl;
    logic [15:0] bubble_count;
    int          total = 0, bad = 0;
    logic [31:0] byp;

    id_ex_pipeline_register dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
        .id_alu_ctrl(id_alu_ctrl), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_result_src(ex_result_src), .ex_alu_ctrl(ex_alu_ctrl), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ctl = {reg_write, mem_read, mem_write, alu_src, branch, jump, result_src[1:0], alu_ctrl[3:0]}
    task automatic set_id(input logic v, input logic [31:0] pc, rd1, rd2,
                          input logic [4:0] rs1, rs2, rd, input logic [11:0] ctl);
        id_valid = v; id_pc = pc; id_pc4 = pc + 32'd4; id_rd1 = rd1; id_rd2 = rd2;
        id_imm = pc ^ 32'hFFFF0000; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        {id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump,
         id_result_src, id_alu_ctrl} = ctl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ex_ctl();
        return {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump,
                ex_result_src, ex_alu_ctrl};
    endfunction

    initial begin
        #3;
        check("reset_valid", ex_valid, 0);
        check("reset_cnt", bubble_count, 0);
        @(negedge clk) rst = 1;
        set_id(1, 32'h10, 32'hABCDEFAB, 32'h11111111, 5'd1, 5'd2, 5'd10, 12'b100101_10_0110);
        step();
        check("load_pc", ex_pc, 32'h10);
        check("load_pc4", ex_pc4, 32'h14);
        check("load_rd1", ex_rd1, 32'hABCDEFAB);
        check("load_rd2", ex_rd2, 32'h11111111);
        check("load_imm", ex_imm, 32'hFFFF0010);
        check("load_regs", {ex_rs1, ex_rs2, ex_rd}, {5'd1, 5'd2, 5'd10});
        check("load_ctl", ex_ctl(), 12'b100101_10_0110);
        check("load_valid", ex_valid, 1);
        check("load_cnt", bubble_count, 0);
        id_valid = 0;
        step();
        check("idle_valid", ex_valid, 0);
        check("idle_pc", ex_pc, 0);
        check("idle_ctl", ex_ctl(), 0);
        check("idle_cnt", bubble_count, 1);
        set_id(1, 32'h10, 32'hABCDEFAB, 32'h11111111, 5'd1, 5'd2, 5'd10, 12'b100101_10_0110);
        step();
        rst = 0;
        #1;
        check("async_valid", ex_valid, 0);
        check("async_pc", ex_pc, 0);
        check("async_rd1", ex_rd1, 0);
        check("async_ctl", ex_ctl(), 0);
        check("async_cnt", bubble_count, 0);
        @(negedge clk) rst = 1;
        step();
        check("rel_rd1", ex_rd1, 32'hABCDEFAB);
        check("rel_rd", ex_rd, 5'd10);
        check("rel_valid", ex_valid, 1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + i, 32'h5A5A0000 + i, 32'h0, 5'd3, 5'd4, 5'd7, 12'b011010_01_1001);
            step();
            check("stall_pc", ex_pc, 32'h10);
            check("stall_rd1", ex_rd1, 32'hABCDEFAB);
            check("stall_ctl", ex_ctl(), 12'b100101_10_0110);
            check("stall_cnt", bubble_count, 0);
        end
        flush = 1;
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_ctl", ex_ctl(), 0);
        check("flush_pc", ex_pc, 0);
        check("flush_rd", ex_rd, 0);
        check("flush_cnt", bubble_count, 1);
        stall = 0;
        step();
        check("flush_nostall_valid", ex_valid, 0);
        check("flush_nostall_cnt", bubble_count, 2);
        flush = 0;
        set_id(1, 32'h40, 32'h1, 32'h2, 5'd3, 5'd4, 5'd0, 12'b010000_01_0011);
        step();
        check("noreg_rd", ex_rd, 5'd0);
        check("noreg_ctl", ex_ctl(), 12'b010000_01_0011);
        check("noreg_cnt", bubble_count, 2);
        set_id(1, 32'h44, 32'h1, 32'h2, 5'd3, 5'd4, 5'd12, 12'b000000_00_0000);
        step();
        check("rd_no_we", ex_rd, 5'd12);
        rst = 0;
        @(negedge clk) rst = 1;
        id_valid = 0;
        for (int i = 0; i < 5; i++) step();
        check("five_bubbles", bubble_count, 5);
        stall = 1;
        force dut.cnt_q = 16'hFFFE;
        step();
        release dut.cnt_q;
        #1;
        check("preload_cnt", bubble_count, 16'hFFFE);
        stall = 0;
        step();
        check("sat_first", bubble_count, 16'hFFFF);
        step();
        step();
        check("sat_hold", bubble_count, 16'hFFFF);
`ifdef FWD_WB_BYPASS_EN
        byp = 32'h22222222;
`else
        byp = 32'h0;
`endif
        wb_we = 1; wb_rd = 5'd5; wb_wd = 32'h22222222;
        set_id(1, 32'h80, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6, 12'b100000_00_0000);
        step();
        check("byp_rd1", ex_rd1, byp);
        check("byp_rd2", ex_rd2, byp);
        check("byp_cnt", bubble_count, 16'hFFFF);
        wb_rd = 5'd0;
        set_id(1, 32'h84, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 12'b100000_00_0000);
        step();
        check("byp_x0_rd1", ex_rd1, 0);
        check("byp_x0_rd2", ex_rd2, 0);
        wb_rd = 5'd7;
        set_id(1, 32'h88, 32'h1, 32'h2, 5'd7, 5'd3, 5'd6, 12'b100000_00_0000);
        step();
        check("byp_one_rd1", ex_rd1, byp == 0 ? 32'h1 : 32'h22222222);
        check("byp_one_rd2", ex_rd2, 32'h2);
        wb_we = 0;
        step();
        check("byp_off_rd1", ex_rd1, 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
